// File: rtl/mbox_pkg.sv
// mbox_pkg: register offsets, flag indices, response FSM states and helpers for the OBI mailbox
package mbox_pkg;

    localparam logic [1:0] MBOX_DATA   = 2'd0;
    localparam logic [1:0] MBOX_STATUS = 2'd1;
    localparam logic [1:0] MBOX_FLAGS  = 2'd2;
    localparam logic [1:0] MBOX_THRESH = 2'd3;

    localparam int OVF_BIT = 0;
    localparam int UNF_BIT = 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WAITING = 2'd1;
    localparam state_t ST_RESP    = 2'd2;

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/mbox_fifo.sv
// mbox_fifo: single-clock word FIFO; push when full and pop when empty are ignored
module mbox_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   wdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [31:0]   head
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok) rptr <= rptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // storage needs no reset; empty slots are never returned
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/obi_mbox_responder.sv
// obi_mbox_responder: OBI responder exposing a word mailbox FIFO with status, sticky flags and threshold irq
module obi_mbox_responder
    import mbox_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 8,
    parameter int WAIT   = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              irq_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT == 0 ? 0 : WAIT - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic          ovf;
    logic          unf;
    logic [7:0]    thresh;
    logic [31:0]   rdata_q;
    logic          irq_q;
    logic          accept;
    logic [1:0]    reg_sel;
    logic          wr;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [31:0]   head;
    logic [31:0]   status_w;
    logic [31:0]   flags_w;
    logic [31:0]   rd_val;
    logic          unused_addr;

    assign gnt_o       = req_i && state != ST_WAITING;
    assign accept      = req_i && gnt_o;
    assign reg_sel     = addr_i[3:2];
    assign wr          = accept && we_i;
    assign push        = wr && reg_sel == MBOX_DATA;
    assign pop         = accept && !we_i && reg_sel == MBOX_DATA;
    assign rvalid_o    = state == ST_RESP;
    assign rdata_o     = rvalid_o ? rdata_q : '0;
    assign irq_o       = irq_q;
    assign unused_addr = ^{addr_i[ADDR_W-1:4], addr_i[1:0]};

    mbox_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (push),
        .pop   (pop),
        .wdata (wdata_i & byte_mask(be_i)),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    // register read mux, evaluated on pre-edge state
    always_comb begin
        status_w = '0;
        status_w[8 +: CW] = count;
        status_w[1] = full;
        status_w[0] = empty;
        flags_w = '0;
        flags_w[OVF_BIT] = ovf;
        flags_w[UNF_BIT] = unf;
        rd_val = reg_sel == MBOX_DATA   ? (empty ? '0 : head) :
                 reg_sel == MBOX_STATUS ? status_w :
                 reg_sel == MBOX_FLAGS  ? flags_w : {24'h0, thresh};
    end

    // response FSM: one outstanding transaction, optional wait states before rvalid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (state == ST_WAITING) begin
            if (cnt == '0) state <= ST_RESP;
            else cnt <= cnt - 4'd1;
        end else if (accept) begin
            state <= WAIT == 0 ? ST_RESP : ST_WAITING;
            cnt   <= WAIT_INIT;
        end else begin
            state <= ST_IDLE;
        end
    end

    // sticky flags (set by bad push/pop, W1C on FLAGS) and threshold register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf    <= 1'b0;
            unf    <= 1'b0;
            thresh <= '0;
        end else begin
            if (push && full) ovf <= 1'b1;
            else if (wr && reg_sel == MBOX_FLAGS && be_i[0] && wdata_i[OVF_BIT]) ovf <= 1'b0;
            if (pop && empty) unf <= 1'b1;
            else if (wr && reg_sel == MBOX_FLAGS && be_i[0] && wdata_i[UNF_BIT]) unf <= 1'b0;
            if (wr && reg_sel == MBOX_THRESH && be_i[0]) thresh <= wdata_i[7:0];
        end
    end

    // capture read data at accept; irq registered from settled count/threshold
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (accept) rdata_q <= we_i ? '0 : rd_val;
            irq_q <= thresh != '0 && 8'(count) >= thresh;
        end
    end

endmodule

// File: tb/tb_obi_mbox_responder.sv
// tb_obi_mbox_responder: randomized and directed checks of the mailbox against a queue-based model
module tb_obi_mbox_responder;

    localparam int DEPTH = 8;
    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst_n, req, we, gnt, rvalid, irq;
    logic [3:0]  be;
    logic [13:0] addr;
    logic [31:0] wdata, rdata;
    logic        w_rst_n, w_req, w_we, w_gnt, w_rvalid, w_irq;
    logic [3:0]  w_be;
    logic [13:0] w_addr;
    logic [31:0] w_wdata, w_rdata;

    always #5 clk = ~clk;

    obi_mbox_responder #(.ADDR_W(14), .DEPTH(DEPTH), .WAIT(0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .irq_o(irq)
    );

    obi_mbox_responder #(.ADDR_W(14), .DEPTH(DEPTH), .WAIT(W)) u_dut_w (
        .clk_i(clk), .rst_ni(w_rst_n), .req_i(w_req), .gnt_o(w_gnt), .we_i(w_we), .be_i(w_be),
        .addr_i(w_addr), .wdata_i(w_wdata), .rvalid_o(w_rvalid), .rdata_o(w_rdata), .irq_o(w_irq)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [7:0]  m_thr = 8'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic w, input logic [1:0] r, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] res = 32'h0;
        int n = q.size();
        if (r == 2'd0 && w) begin
            if (n == DEPTH) m_ovf = 1'b1;
            else q.push_back(d & {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}});
        end else if (r == 2'd0) begin
            if (n == 0) m_unf = 1'b1;
            else res = q.pop_front();
        end else if (r == 2'd1) begin
            res = w ? 32'h0 : {16'h0, 8'(n), 6'h0, n == DEPTH, n == 0};
        end else if (r == 2'd2) begin
            if (w) begin
                m_ovf = m_ovf & ~d[0];
                m_unf = m_unf & ~d[1];
            end else res = {30'h0, m_unf, m_ovf};
        end else begin
            if (w) m_thr = d[7:0];
            else res = {24'h0, m_thr};
        end
        return res;
    endfunction

    function automatic logic m_irq();
        return m_thr != 8'h0 && q.size() >= int'(m_thr);
    endfunction

    task automatic bus(input logic w, input logic [1:0] r, input logic [31:0] d, input logic [3:0] b, output logic [31:0] rd);
        logic [31:0] exp;
        @(negedge clk);
        req = 1'b1; we = w; wdata = d; be = b;
        addr = 14'($urandom); addr[3:2] = r;
        exp = model(w, r, d, b);
        #1 check("gnt", gnt, 1);
        @(negedge clk);
        req = 1'b0;
        check("rvalid", rvalid, 1);
        rd = rdata;
        if (!w) check("rdata", rdata, exp);
        @(negedge clk);
        check("rvalid_drop", rvalid, 0);
        check("rdata_idle", rdata, 0);
        check("irq", irq, m_irq());
    endtask

    task automatic wbus(input logic w, input logic [1:0] r, input logic [31:0] d, output logic [31:0] rd);
        int lat;
        int t;
        @(negedge clk);
        w_req = 1'b1; w_we = w; w_addr = {10'h0, r, 2'b00}; w_wdata = d; w_be = 4'hF;
        t = 0;
        #1;
        while (!w_gnt && t < 20) begin
            @(negedge clk);
            #1 t++;
        end
        check("w_gnt", w_gnt, 1);
        @(posedge clk);
        @(negedge clk);
        w_req = 1'b0;
        lat = 1;
        while (!w_rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("w_latency", lat, W + 1);
        rd = w_rdata;
    endtask

    logic [31:0] rd, e1, e2;
    logic [31:0] got[$];
    int ng, pulses;

    initial begin
        rst_n = 1'b0; w_rst_n = 1'b0;
        req = 1'b1; we = 1'b0; be = 4'hF; addr = '0; wdata = '0;
        w_req = 1'b1; w_we = 1'b0; w_be = 4'hF; w_addr = '0; w_wdata = '0;
        #2;
        check("rst_gnt", gnt, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_irq", irq, 0);
        check("rst_w_gnt", w_gnt, 1);
        req = 1'b0; w_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; w_rst_n = 1'b1;

        bus(0, 2'd1, 0, 4'hF, rd); check("rst_status", rd, 32'h1);
        bus(0, 2'd2, 0, 4'hF, rd); check("rst_flags", rd, 32'h0);
        bus(0, 2'd3, 0, 4'hF, rd); check("rst_thresh", rd, 32'h0);

        bus(1, 2'd0, 32'h11111111, 4'hF, rd);
        bus(1, 2'd0, 32'h22222222, 4'hF, rd);
        bus(0, 2'd1, 0, 4'hF, rd); check("basic_status", rd, 32'h200);
        bus(0, 2'd0, 0, 4'hF, rd); check("basic_pop1", rd, 32'h11111111);
        bus(0, 2'd0, 0, 4'hF, rd); check("basic_pop2", rd, 32'h22222222);

        bus(1, 2'd0, 32'hAABBCCDD, 4'b0101, rd);
        bus(0, 2'd0, 0, 4'hF, rd); check("byte_mask", rd, 32'h00BB00DD);

        for (int i = 1; i <= DEPTH + 1; i++) bus(1, 2'd0, 32'(i), 4'hF, rd);
        bus(0, 2'd2, 0, 4'hF, rd); check("ovf_flags", rd, 32'h1);
        bus(0, 2'd1, 0, 4'hF, rd); check("ovf_status", rd, 32'h802);
        for (int i = 1; i <= DEPTH; i++) begin
            bus(0, 2'd0, 0, 4'hF, rd); check("drain", rd, 32'(i));
        end
        bus(0, 2'd0, 0, 4'hF, rd); check("unf_data", rd, 32'h0);
        bus(0, 2'd2, 0, 4'hF, rd); check("unf_flags", rd, 32'h3);
        bus(1, 2'd2, 32'h1, 4'hF, rd);
        bus(0, 2'd2, 0, 4'hF, rd); check("w1c_flags", rd, 32'h2);
        bus(1, 2'd2, 32'h2, 4'hF, rd);

        bus(1, 2'd3, 32'h3, 4'hF, rd);
        for (int i = 0; i < 3; i++) bus(1, 2'd0, $urandom, 4'hF, rd);
        check("thr_irq_set", irq, 1);
        bus(0, 2'd0, 0, 4'hF, rd);
        check("thr_irq_clr", irq, 0);
        bus(1, 2'd3, 32'h0, 4'hF, rd);
        for (int i = 0; i < DEPTH; i++) bus(1, 2'd0, $urandom, 4'hF, rd);
        check("thr_zero_irq", irq, 0);

        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 14'h4; be = 4'hF;
        e1 = model(0, 2'd1, 0, 4'hF);
        #1 check("b2b_gnt1", gnt, 1);
        @(negedge clk);
        e2 = model(0, 2'd1, 0, 4'hF);
        check("b2b_rvalid1", rvalid, 1);
        check("b2b_rdata1", rdata, e1);
        #1 check("b2b_gnt2", gnt, 1);
        @(negedge clk);
        req = 1'b0;
        check("b2b_rvalid2", rvalid, 1);
        check("b2b_rdata2", rdata, e2);
        @(negedge clk);
        check("b2b_idle", rvalid, 0);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] r;
            logic w;
            r = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            w = 1'($urandom);
            if (r == 2'd0) bus(w, r, $urandom, 4'($urandom), rd);
            else if (r == 2'd3) bus(w, r, 32'($urandom_range(0, 9)), 4'hF, rd);
            else bus(w, r, 32'($urandom_range(0, 3)), 4'hF, rd);
        end

        wbus(1, 2'd0, 32'hA5A5_0001, rd);
        wbus(1, 2'd0, 32'h5A5A_0002, rd);
        @(negedge clk);
        w_req = 1'b1; w_we = 1'b0; w_addr = 14'h0;
        ng = 0; pulses = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("w_gnt_c%0d", c), w_gnt, (c == 0 || c == W + 1));
            check($sformatf("w_rvalid_c%0d", c), w_rvalid, (c == W + 1 || c == 2 * (W + 1)));
            if (w_rvalid) begin
                pulses++;
                got.push_back(w_rdata);
            end
            if (w_req && w_gnt) ng++;
            @(negedge clk);
            if (ng == 2) w_req = 1'b0;
        end
        check("w_pulses", pulses, 2);
        check("w_rd0", got.size() > 0 ? got[0] : 32'hDEAD, 32'hA5A5_0001);
        check("w_rd1", got.size() > 1 ? got[1] : 32'hDEAD, 32'h5A5A_0002);

        wbus(1, 2'd0, 32'hC0DE_0003, rd);
        @(negedge clk);
        w_req = 1'b1; w_we = 1'b0; w_addr = 14'h0;
        #1 check("w_rst_gnt", w_gnt, 1);
        @(negedge clk);
        w_req = 1'b0;
        #1 check("w_rst_waiting", w_gnt | w_rvalid, 0);
        w_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        w_rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (w_rvalid) pulses++;
        end
        check("w_rst_no_rvalid", pulses, 0);
        wbus(0, 2'd1, 0, rd);
        check("w_rst_status", rd, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/obi_mbox_responder.md
# obi_mbox_responder

Memory-mapped mailbox peripheral that sits on a core data bus as an OBI-style responder: it answers `req`/`gnt`/`rvalid` transactions issued by an Ibex-class core, the same way the SRAM slaves behind the interconnect do. It holds a word FIFO that one core fills through writes and another core drains through reads, plus status, sticky-error and interrupt-threshold registers. An optional programmable wait-state count emulates slow slaves for bus testing.

## Interface
- `ADDR_W`, 14, byte-address width of `addr_i`. This matches the core data bus.
- `DEPTH`, 8, FIFO depth in 32-bit words. It must be a power of 2 and ≥ 2.
- `WAIT`, 0, extra cycles between grant and `rvalid_o` (0..15).

One clock; reset is asynchronous and active-low.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  request accepted this cycle.
- `we_i`  in  1  1 = write, 0 = read.
- `be_i`  in  4  byte enables.
- `addr_i`  in  ADDR_W  byte address. Only `[3:2]` is decoded.
- `wdata_i`  in  32  write data.
- `rvalid_o`  out  1  response valid, one pulse per accepted request.
- `rdata_o`  out  32  read data. It is valid with `rvalid_o` and is 0 otherwise.
- `irq_o`  out  1  level interrupt for the threshold.

## Operation

**Register map** (`addr_i[3:2]`):
- **0 DATA:**
  - Write pushes `wdata_i` masked by `be_i`; disabled bytes are stored as 0.
  - Push when full: the data is dropped and `OVF` is set.
  - Read pops the head and returns it.
  - Pop when empty: returns 0 and sets `UNF`.
- **1 STATUS (RO):** `{count` in `[15:8]`, `full` in `[1]`, `empty` in `[0]}`; other bits 0. Writes are ignored.
- **2 FLAGS:** `OVF` in `[0]`, `UNF` in `[1]`. Writing 1 clears a bit (W1C).
- **3 THRESH:** RW, `[7:0]`.

**Interrupt and widths:**
- `irq_o` = (`THRESH` ≠ 0) && (`count` ≥ `THRESH`).
- `count` width is `$clog2(DEPTH+1)`, zero-extended into STATUS.
- Read/write pointers are `$clog2(DEPTH)` bits and wrap naturally.

**Transactions:**
- A transaction is accepted on any cycle with `req_i` && `gnt_o`.
- All side effects (push, pop, W1C, THRESH write, flag set) take effect at the accepting clock edge.
- Read data is captured from pre-edge state. A STATUS read returns the count before that transaction's effects.

**Response FSM** (IDLE, WAITING, RESP):
- IDLE: on accept, go to RESP if `WAIT` = 0, otherwise go to WAITING with `cnt` = `WAIT`-1.
- WAITING: `gnt_o` = 0. `cnt` decrements each cycle; at `cnt` = 0, go to RESP.
- RESP: `rvalid_o` = 1. A new accept in the same cycle re-enters WAITING or RESP per `WAIT`; otherwise go to IDLE.
- `gnt_o` = `req_i` && (state ≠ WAITING), combinational. At most one outstanding transaction.

**Reset values:**
- FIFO empty, pointers 0, `count` 0.
- `OVF`/`UNF` 0, `THRESH` 0.
- FSM in IDLE.
- `gnt_o` follows `req_i`; `rvalid_o`, `rdata_o`, `irq_o` are 0.

**Reset mid-transaction:** the pending response is discarded and no `rvalid_o` is issued after reset release.

## Timing
- With `WAIT` = 0:
  - Grant is zero-wait.
  - `rvalid_o` rises exactly 1 cycle after the accept edge.
  - Back-to-back accepts give one `rvalid_o` per cycle.
- With `WAIT` = N: `rvalid_o` comes N+1 cycles after accept. `gnt_o` is low for the N cycles in between.
- `irq_o` is registered from the post-edge `count`/`THRESH`, so it updates 1 cycle after the causing accept.
- Simultaneous flag set and W1C is impossible (single port).
- A FLAGS write that also overflows cannot occur, because DATA and FLAGS are different addresses.

## Structure
- Package `mbox_pkg`:
  - register offsets `MBOX_DATA`/`STATUS`/`FLAGS`/`THRESH`
  - flag bit indices `OVF_BIT`, `UNF_BIT`
  - FSM state enum
- Sub-module `mbox_fifo`: synchronous single-clock FIFO with `push`, `pop`, `full`, `empty`, `count`, `head`. It ignores a push when full and a pop when empty.
- The top level holds the FSM, address decode, flags and `THRESH`.

## Test plan
- **Basic FIFO order** (`WAIT`=0): write DATA 0x11111111 then 0x22222222, read STATUS, read DATA twice → STATUS = 0x00000200; reads return 0x11111111 then 0x22222222; each `rvalid_o` comes 1 cycle after its grant.
- **Byte masking:** write DATA 0xAABBCCDD with `be` = 4'b0101, then read DATA → 0x00BB00DD.
- **Overflow and underflow:**
  - 9 writes (DEPTH=8): FLAGS read → 0x1, STATUS full = 1, 9th word lost.
  - Drain 8 words plus one extra read: extra read returns 0, FLAGS → 0x3.
  - Write FLAGS 0x1: FLAGS reads 0x2.
- **Threshold interrupt:** THRESH = 3; after the 3rd push `irq_o` = 1 on the following cycle; one pop → `irq_o` = 0. THRESH = 0 keeps `irq_o` = 0 at any count.
- **Wait states** (`WAIT`=3): hold `req_i` high for 2 reads → `gnt_o` pattern 1,0,0,0,1; `rvalid_o` 4 cycles after each grant; exactly 2 `rvalid_o` pulses.
- **Reset mid-transaction:** assert `rst_ni` = 0 during WAITING → no `rvalid_o` after release; STATUS reads 0x1 (empty).
